// File: rtl/lc3_io_pkg.sv
// rtl/lc3_io_pkg.sv - shared addresses, status bit indices and display FSM states
package lc3_io_pkg;

   localparam logic [15:0] ADDR_KBDR = 16'h03F0;
   localparam logic [15:0] ADDR_KBSR = 16'h03F1;
   localparam logic [15:0] ADDR_DDR  = 16'h03F2;
   localparam logic [15:0] ADDR_DSR  = 16'h03F3;

   localparam int RDY_BIT = 15;
   localparam int IE_BIT  = 14;
   localparam int OVR_BIT = 13;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } disp_state_t;

endpackage

// File: rtl/lc3_io_fifo.sv
// rtl/lc3_io_fifo.sv - synchronous keystroke FIFO with explicit pointer wrap
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Push is refused when full even if a pop happens in the same cycle.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_dout    = r_mem[r_rd_ptr];

   // Storage needs no reset: an empty count masks stale entries.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap at DEPTH; count tracks occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/lc3_io_devices.sv
// rtl/lc3_io_devices.sv - LC-3 keyboard/display memory-mapped register block
module lc3_io_devices
   import lc3_io_pkg::*;
#(
   parameter int KBD_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_data,
   input  logic        i_ld_kbsr,
   input  logic        i_ld_ddr,
   input  logic        i_ld_dsr,
   input  logic        i_kbdr_rd,
   input  logic        i_kbd_valid,
   input  logic [7:0]  i_kbd_data,
   output logic        o_kbd_ready,
   output logic        o_disp_valid,
   output logic [7:0]  o_disp_data,
   input  logic        i_disp_ready,
   output logic [15:0] o_kbdr_out,
   output logic [15:0] o_kbsr_out,
   output logic [15:0] o_dsr_out,
   output logic        o_kbd_irq,
   output logic        o_disp_irq
);

   disp_state_t r_state;
   disp_state_t w_next_state;
   logic        r_kbsr_ie;
   logic        r_dsr_ie;
   logic        r_dsr_ovr;
   logic [7:0]  r_disp_data;
   logic [7:0]  w_fifo_dout;
   logic        w_fifo_empty;
   logic        w_fifo_full;
   logic        w_unused;

   assign w_unused = &{1'b0, i_data[15], i_data[13:8]};

   io_fifo #(
      .WIDTH (8),
      .DEPTH (KBD_DEPTH)
   ) u_kbd_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_kbd_valid),
      .i_pop   (i_kbdr_rd),
      .i_din   (i_kbd_data),
      .o_dout  (w_fifo_dout),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign o_kbd_ready  = !w_fifo_full;
   assign o_disp_valid = (r_state == SEND);
   assign o_disp_data  = r_disp_data;
   assign o_kbd_irq    = !w_fifo_empty && r_kbsr_ie;
   assign o_disp_irq   = (r_state == IDLE) && r_dsr_ie;

   // Read-side views assembled straight from registered state.
   always_comb begin
      o_kbdr_out          = '0;
      o_kbsr_out          = '0;
      o_dsr_out           = '0;
      if (!w_fifo_empty) begin
         o_kbdr_out[7:0]  = w_fifo_dout;
      end
      o_kbsr_out[RDY_BIT] = !w_fifo_empty;
      o_kbsr_out[IE_BIT]  = r_kbsr_ie;
      o_dsr_out[RDY_BIT]  = (r_state == IDLE);
      o_dsr_out[IE_BIT]   = r_dsr_ie;
      o_dsr_out[OVR_BIT]  = r_dsr_ovr;
   end

   // Display FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Display FSM next state: a DDR write starts a send, the handshake ends it.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (i_ld_ddr) w_next_state = SEND;
         SEND: if (i_disp_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // DDR latches only when idle, so the character stays stable during SEND.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_disp_data <= '0;
      end else if (i_ld_ddr && (r_state == IDLE)) begin
         r_disp_data <= i_data[7:0];
      end
   end

   // Status control bits; an overrun set beats a DSR clear in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_kbsr_ie <= 1'b0;
         r_dsr_ie  <= 1'b0;
         r_dsr_ovr <= 1'b0;
      end else begin
         if (i_ld_kbsr) begin
            r_kbsr_ie <= i_data[IE_BIT];
         end
         if (i_ld_dsr) begin
            r_dsr_ie <= i_data[IE_BIT];
         end
         if (i_ld_ddr && (r_state == SEND)) begin
            r_dsr_ovr <= 1'b1;
         end else if (i_ld_dsr) begin
            r_dsr_ovr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lc3_io_devices.sv
// tb/tb_lc3_io_devices.sv - scoreboard bench for the LC-3 I/O register block
module tb_lc3_io_devices;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] data;
   logic        ld_kbsr, ld_ddr, ld_dsr, kbdr_rd;
   logic        kbd_valid;
   logic [7:0]  kbd_data;
   logic        kbd_ready;
   logic        disp_valid;
   logic [7:0]  disp_data;
   logic        disp_ready;
   logic [15:0] kbdr_out, kbsr_out, dsr_out;
   logic        kbd_irq, disp_irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] kq[$];
   logic [7:0] dq[$];
   logic       m_ovr;
   logic       m_dsr_ie;
   logic       m_kbsr_ie;
   logic [15:0] exp16;

   lc3_io_devices #(.KBD_DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (data),
      .i_ld_kbsr    (ld_kbsr),
      .i_ld_ddr     (ld_ddr),
      .i_ld_dsr     (ld_dsr),
      .i_kbdr_rd    (kbdr_rd),
      .i_kbd_valid  (kbd_valid),
      .i_kbd_data   (kbd_data),
      .o_kbd_ready  (kbd_ready),
      .o_disp_valid (disp_valid),
      .o_disp_data  (disp_data),
      .i_disp_ready (disp_ready),
      .o_kbdr_out   (kbdr_out),
      .o_kbsr_out   (kbsr_out),
      .o_dsr_out    (dsr_out),
      .o_kbd_irq    (kbd_irq),
      .o_disp_irq   (disp_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_kbdr();
      return (kq.size() == 0) ? 16'h0000 : {8'h00, kq[0]};
   endfunction

   function automatic logic [15:0] exp_kbsr();
      return {(kq.size() != 0), m_kbsr_ie, 14'b0};
   endfunction

   // One keyboard cycle: model mirrors the accept/pop rules from the registered count.
   task automatic kbd_cycle(input logic push, input logic [7:0] ch, input logic pop);
      int n;
      n = kq.size();
      kbd_valid = push;
      kbd_data  = ch;
      kbdr_rd   = pop;
      cyc();
      if (pop && n > 0) void'(kq.pop_front());
      if (push && n < DEPTH) kq.push_back(ch);
      kbd_valid = 1'b0;
      kbdr_rd   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      kq.delete(); dq.delete();
      m_ovr = 1'b0; m_dsr_ie = 1'b0; m_kbsr_ie = 1'b0;
      cyc(); cyc();
      checks++; if (dsr_out !== 16'h8000) begin errors++; $display("FAIL reset_dsr got %h exp %h", dsr_out, 16'h8000); end
      checks++; if (kbsr_out !== 16'h0000) begin errors++; $display("FAIL reset_kbsr got %h exp %h", kbsr_out, 16'h0000); end
      checks++; if (kbdr_out !== 16'h0000) begin errors++; $display("FAIL reset_kbdr got %h exp %h", kbdr_out, 16'h0000); end
      checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready got %b exp 1", kbd_ready); end
      checks++; if (disp_valid !== 1'b0 || disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp got %b/%h exp 0/00", disp_valid, disp_data); end
      checks++; if (kbd_irq !== 1'b0 || disp_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b%b exp 00", kbd_irq, disp_irq); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_kbd_basic();
      kbd_cycle(1'b1, 8'h41, 1'b0);
      kbd_cycle(1'b1, 8'h42, 1'b0);
      checks++; if (kbsr_out !== 16'h8000) begin errors++; $display("FAIL kbd_rdy got %h exp %h", kbsr_out, 16'h8000); end
      exp16 = exp_kbdr();
      checks++; if (kbdr_out !== exp16) begin errors++; $display("FAIL kbd_head_a got %h exp %h", kbdr_out, exp16); end
      for (int i = 0; i < 3; i++) begin
         kbd_cycle(1'b0, 8'h00, 1'b1);
         exp16 = exp_kbdr();
         checks++; if (kbdr_out !== exp16) begin errors++; $display("FAIL kbd_read%0d got %h exp %h", i, kbdr_out, exp16); end
         exp16 = exp_kbsr();
         checks++; if (kbsr_out !== exp16) begin errors++; $display("FAIL kbd_stat%0d got %h exp %h", i, kbsr_out, exp16); end
      end
   endtask

   task automatic test_kbd_full();
      for (int i = 0; i < DEPTH; i++) kbd_cycle(1'b1, 8'h10 + 8'(i), 1'b0);
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", kbd_ready); end
      kbd_cycle(1'b1, 8'h99, 1'b0);
      exp16 = exp_kbdr();
      checks++; if (kbdr_out !== exp16) begin errors++; $display("FAIL full_head got %h exp %h", kbdr_out, exp16); end
      kbd_cycle(1'b1, 8'h98, 1'b1);
      checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL pop_when_full_ready got %b exp 1", kbd_ready); end
      exp16 = exp_kbdr();
      checks++; if (kbdr_out !== exp16) begin errors++; $display("FAIL pop_when_full_head got %h exp %h", kbdr_out, exp16); end
      kbd_cycle(1'b1, 8'h20, 1'b1);
      checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL pushpop_ready got %b exp 1", kbd_ready); end
      while (kq.size() > 0) begin
         exp16 = exp_kbdr();
         checks++; if (kbdr_out !== exp16) begin errors++; $display("FAIL drain got %h exp %h", kbdr_out, exp16); end
         kbd_cycle(1'b0, 8'h00, 1'b1);
      end
      checks++; if (kbsr_out !== 16'h0000) begin errors++; $display("FAIL drained_kbsr got %h exp %h", kbsr_out, 16'h0000); end
   endtask

   // Write DDR; scoreboard only takes the character when the FSM is idle.
   task automatic ddr_write(input logic [15:0] d, input logic rdy);
      logic idle;
      idle = (dq.size() == 0);
      data = d; ld_ddr = 1'b1; disp_ready = rdy;
      cyc();
      if (idle) dq.push_back(d[7:0]);
      else m_ovr = 1'b1;
      if (!idle && rdy) void'(dq.pop_front());
      ld_ddr = 1'b0; disp_ready = 1'b0;
   endtask

   task automatic handshake();
      checks++; if (dq.size() == 0 || disp_data !== dq[0] || disp_valid !== 1'b1) begin
         errors++; $display("FAIL hs_data got %b/%h exp 1/%h", disp_valid, disp_data, (dq.size() != 0) ? dq[0] : 8'hxx); end
      disp_ready = 1'b1;
      cyc();
      if (dq.size() != 0) void'(dq.pop_front());
      disp_ready = 1'b0;
   endtask

   function automatic logic [15:0] exp_dsr();
      return {(dq.size() == 0), m_dsr_ie, m_ovr, 13'b0};
   endfunction

   task automatic test_display();
      ddr_write(16'h1248, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (disp_data !== 8'h48 || disp_valid !== 1'b1) begin errors++; $display("FAIL send_hold%0d got %b/%h exp 1/48", i, disp_valid, disp_data); end
         exp16 = exp_dsr();
         checks++; if (dsr_out !== exp16) begin errors++; $display("FAIL send_dsr%0d got %h exp %h", i, dsr_out, exp16); end
         cyc();
      end
      handshake();
      checks++; if (dsr_out !== 16'h8000 || disp_valid !== 1'b0) begin errors++; $display("FAIL hs_done got %h/%b exp 8000/0", dsr_out, disp_valid); end
   endtask

   task automatic test_overrun();
      ddr_write(16'h0041, 1'b0);
      ddr_write(16'h0042, 1'b0);
      checks++; if (disp_data !== 8'h41) begin errors++; $display("FAIL ovr_data got %h exp 41", disp_data); end
      checks++; if (dsr_out !== 16'h2000) begin errors++; $display("FAIL ovr_dsr got %h exp %h", dsr_out, 16'h2000); end
      handshake();
      checks++; if (dsr_out !== 16'hA000) begin errors++; $display("FAIL ovr_idle got %h exp %h", dsr_out, 16'hA000); end
      data = 16'h4000; ld_dsr = 1'b1; cyc(); ld_dsr = 1'b0;
      m_dsr_ie = 1'b1; m_ovr = 1'b0;
      checks++; if (dsr_out !== 16'hC000 || disp_irq !== 1'b1) begin errors++; $display("FAIL dsr_wr got %h/%b exp c000/1", dsr_out, disp_irq); end
      // ld_ddr on the handshake edge still counts as an overrun.
      ddr_write(16'h0055, 1'b0);
      ddr_write(16'h0066, 1'b1);
      exp16 = exp_dsr();
      checks++; if (dsr_out !== exp16 || disp_data !== 8'h55) begin errors++; $display("FAIL hs_ovr got %h/%h exp %h/55", dsr_out, disp_data, exp16); end
      // DSR clear and overrun set in one cycle: set wins.
      ddr_write(16'h0077, 1'b0);
      data = 16'h4000; ld_dsr = 1'b1; ld_ddr = 1'b1; cyc(); ld_dsr = 1'b0; ld_ddr = 1'b0;
      exp16 = exp_dsr();
      checks++; if (dsr_out !== exp16) begin errors++; $display("FAIL set_wins got %h exp %h", dsr_out, exp16); end
      handshake();
      data = 16'h0000; ld_dsr = 1'b1; cyc(); ld_dsr = 1'b0;
      m_dsr_ie = 1'b0; m_ovr = 1'b0;
      checks++; if (dsr_out !== 16'h8000 || disp_irq !== 1'b0) begin errors++; $display("FAIL dsr_clr got %h/%b exp 8000/0", dsr_out, disp_irq); end
   endtask

   task automatic test_irq_reset();
      data = 16'h4000; ld_kbsr = 1'b1; cyc(); ld_kbsr = 1'b0;
      m_kbsr_ie = 1'b1;
      checks++; if (kbd_irq !== 1'b0 || kbsr_out !== 16'h4000) begin errors++; $display("FAIL kirq_empty got %b/%h exp 0/4000", kbd_irq, kbsr_out); end
      kbd_cycle(1'b1, 8'h0D, 1'b0);
      exp16 = exp_kbsr();
      checks++; if (kbd_irq !== 1'b1 || kbsr_out !== exp16) begin errors++; $display("FAIL kirq_set got %b/%h exp 1/%h", kbd_irq, kbsr_out, exp16); end
      ddr_write(16'h0031, 1'b0);
      checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_send got %b exp 1", disp_valid); end
      #2 rst_n = 1'b0;
      #1;
      kq.delete(); dq.delete(); m_kbsr_ie = 1'b0; m_ovr = 1'b0; m_dsr_ie = 1'b0;
      checks++; if (dsr_out !== 16'h8000 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin errors++; $display("FAIL async_disp got %h/%b/%h exp 8000/0/00", dsr_out, disp_valid, disp_data); end
      exp16 = exp_kbsr();
      checks++; if (kbsr_out !== exp16 || kbdr_out !== 16'h0000 || kbd_ready !== 1'b1) begin errors++; $display("FAIL async_kbd got %h/%h/%b exp %h/0000/1", kbsr_out, kbdr_out, kbd_ready, exp16); end
      checks++; if (kbd_irq !== 1'b0 || disp_irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b%b exp 00", kbd_irq, disp_irq); end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      rst_n = 1'b0; data = '0; ld_kbsr = 0; ld_ddr = 0; ld_dsr = 0; kbdr_rd = 0;
      kbd_valid = 0; kbd_data = '0; disp_ready = 0;
      test_reset();
      test_kbd_basic();
      test_kbd_full();
      test_display();
      test_overrun();
      test_irq_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_io_devices.md
# lc3_io_devices

Device-side register block for the LC-3 memory-mapped I/O window at 0x03F0–0x03F3. It owns KBDR/KBSR (keyboard input) and DDR/DSR (display output) and responds to the load strobes and read select decoded by the address controller. It buffers incoming keystrokes in a small FIFO and drives a valid/ready handshake toward the display. Its three 16-bit read outputs feed the datapath's MDR input mux.

## Interface
- KBD_DEPTH, 4 — keyboard FIFO entries; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  16  write data from MDR
- ld_kbsr  in  1  write KBSR from `data`
- ld_ddr  in  1  write DDR from `data`
- ld_dsr  in  1  write DSR from `data`
- kbdr_rd  in  1  one-cycle pulse per CPU read of 0x03F0; pops FIFO
- kbd_valid  in  1  keyboard offers a character
- kbd_data  in  8  ASCII character from keyboard
- kbd_ready  out  1  FIFO can accept; = !full
- disp_valid  out  1  DDR character pending for display
- disp_data  out  8  character to display
- disp_ready  in  1  display accepts the character
- kbdr_out  out  16  {8'h00, FIFO head}; 0 when empty
- kbsr_out  out  16  {RDY, IE, 14'b0}
- dsr_out  out  16  {RDY, IE, OVR, 13'b0}
- kbd_irq  out  1  KBSR.RDY & KBSR.IE
- disp_irq  out  1  DSR.RDY & DSR.IE

## Operation
- Keyboard path: push on `kbd_valid & kbd_ready`; pop on `kbdr_rd` when non-empty. KBSR.RDY = FIFO non-empty. KBSR.IE is the only writable bit; `ld_kbsr` sets IE = data[14].
- Pop while empty: ignored, with no state change.
- Push and pop in the same cycle with 0 < count < KBD_DEPTH: count is unchanged and the head advances.
- When full, `kbd_ready` = 0 (registered count). A same-cycle pop does not open a push slot.
- Display FSM:
  - IDLE: DSR.RDY = 1, `disp_valid` = 0.
  - `ld_ddr` in IDLE: latch data[7:0] into `disp_data` and go to SEND.
  - SEND: DSR.RDY = 0, `disp_valid` = 1, `disp_data` held stable.
  - `disp_valid & disp_ready` in SEND: go to IDLE.
- `ld_ddr` while in SEND: the write is dropped, `disp_data` is unchanged, and sticky DSR.OVR is set.
- If `ld_ddr` coincides with the SEND→IDLE handshake, it is still treated as a write during SEND: the write is dropped and OVR is set.
- `ld_dsr`: IE = data[14] and OVR cleared. Writing RDY has no effect.
- If `ld_dsr` and an OVR-setting `ld_ddr` occur in the same cycle, set wins.
- The strobes `ld_kbsr`, `ld_ddr` and `ld_dsr` are mutually exclusive by decode; behaviour when more than one is asserted is unspecified.
- Upper DDR bits data[15:8] are discarded.

## Timing
- Reset values:
  - FIFO empty.
  - `kbdr_out` = 0x0000, `kbsr_out` = 0x0000.
  - `dsr_out` = 0x8000, FSM in IDLE.
  - `disp_valid` = 0, `disp_data` = 0x00.
  - `kbd_ready` = 1.
  - `kbd_irq` = 0, `disp_irq` = 0.
- Reset mid-operation: a pending display character and all FIFO contents are discarded immediately.
- Keystroke accepted at edge N: KBSR.RDY and `kbdr_out` valid from N+1. Read outputs are combinational from registers, with no extra latency.
- `kbdr_rd` at edge N: the next head (or 0x0000) is visible from N+1. The datapath asserts `kbdr_rd` for exactly one cycle per load; each asserted cycle pops one entry.
- `ld_ddr` at edge N: `disp_valid` = 1 and DSR.RDY = 0 from N+1.
- Handshake at edge M: `disp_valid` = 0 and DSR.RDY = 1 from M+1. Minimum SEND duration is 1 cycle.
- `disp_valid` never drops without `disp_ready`.
- IRQ outputs are combinational from registered bits.

## Structure
- Package `lc3_io_pkg` holds:
  - Addresses KBDR=16'h03F0, KBSR=16'h03F1, DDR=16'h03F2, DSR=16'h03F3.
  - Bit indices RDY=15, IE=14, OVR=13.
  - Display FSM state enum {IDLE, SEND}.
- Sub-module `io_fifo`: synchronous FIFO, parameterised width (8) and depth.
  - Ports: push, pop, din, dout, empty, full.
  - Pointer wrap at DEPTH; count width clog2(DEPTH)+1.

## Test plan
- Reset: deassert `rst_n` → `dsr_out`=0x8000, `kbsr_out`=0x0000, `kbd_ready`=1, `disp_valid`=0.
- Push 'A' (0x41) then 'B' (0x42) → `kbsr_out`=0x8000 and `kbdr_out`=0x0041. After `kbdr_rd`: `kbdr_out`=0x0042. After second `kbdr_rd`: `kbdr_out`=0x0000, `kbsr_out`=0x0000. A third `kbdr_rd` causes no change.
- Push 4 characters with KBD_DEPTH=4 → `kbd_ready`=0 and a 5th `kbd_valid` is not accepted. `kbdr_rd` and `kbd_valid` in the same cycle → count 3, `kbd_ready`=1 next cycle.
- `ld_ddr` data=0x1248 with `disp_ready` held low for 3 cycles → `disp_data`=0x48 stable, `dsr_out`=0x0000. Raise `disp_ready` → `dsr_out`=0x8000 the next cycle.
- `ld_ddr` 0x0041, then `ld_ddr` 0x0042 while in SEND → `disp_data` stays 0x41 and `dsr_out`=0x2000. Complete the handshake → 0xA000. `ld_dsr` data=0x4000 → `dsr_out`=0xC000 and `disp_irq`=1.
- `ld_kbsr` data=0x4000 with the FIFO empty → `kbd_irq`=0. Push 0x0D → `kbd_irq`=1. Assert `rst_n`=0 while in SEND → all outputs return to reset values asynchronously.
